// File: rtl/mem_access_unit_pkg.sv
// Shared CPU-side constants for the data memory path: widths, memory depth,
// controller state encodings and the address range helper.
package mem_access_unit_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MEM_DEPTH = 6536;

  typedef logic [1:0] mau_state_t;

  localparam mau_state_t ST_IDLE    = 2'd0;
  localparam mau_state_t ST_ACCESS  = 2'd1;
  localparam mau_state_t ST_CAPTURE = 2'd2;
  localparam mau_state_t ST_RESP    = 2'd3;

  // Unsigned compare over the full address width so huge addresses never wrap.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(MEM_DEPTH);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of the CPU request/response channels and the memory pins seen by
// the access unit. The slave view belongs to the unit, master to the CPU,
// memory to the data memory model.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_datain;
  logic [DATA_W-1:0] mem_dataout;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready, mem_dataout,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_address, mem_datain
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport memory (
    input  mem_read, mem_write, mem_address, mem_datain,
    output mem_dataout
  );

endinterface

// File: rtl/mem_access_unit.sv
// Initiator-side controller for the single-port data memory. Takes one
// load/store at a time, pulses the memory strobe for one cycle, waits out
// the registered read latency and returns the result on a response channel.
// Addresses beyond the memory depth are answered with an error and never
// reach the memory.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input logic            clock,
  input logic            reset,
  mem_access_unit_if.slave bus
);

  mau_state_t        state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_datain_q, mem_datain_d;
  logic              is_write_q, is_write_d;

  // Next-state and next-output logic; every output is taken from a flop.
  always_comb begin
    state_d       = state_q;
    req_ready_d   = req_ready_q;
    resp_valid_d  = resp_valid_q;
    resp_rdata_d  = resp_rdata_q;
    resp_err_d    = resp_err_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_datain_d  = mem_datain_q;
    is_write_d    = is_write_q;

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          is_write_d  = bus.req_write;
          if (addr_in_range(bus.req_addr)) begin
            mem_address_d = bus.req_addr;
            mem_datain_d  = bus.req_wdata;
            mem_read_d    = ~bus.req_write;
            mem_write_d   = bus.req_write;
            state_d       = ST_ACCESS;
          end else begin
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            resp_valid_d = 1'b1;
            state_d      = ST_RESP;
          end
        end
      end

      ST_ACCESS: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        state_d     = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        resp_rdata_d = is_write_q ? '0 : bus.mem_dataout;
        resp_err_d   = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = ST_RESP;
      end

      ST_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset wins over any handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_datain_q  <= '0;
      is_write_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_datain_q  <= mem_datain_d;
      is_write_q    <= is_write_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_datain  = mem_datain_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a table of directed requests,
// hand-written back-to-back and mid-transaction reset sequences, and a
// randomized phase checked against a simple memory reference model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic        expErr;
    logic [31:0] expRdata;
    int          expLat;
    int          expRd;
    int          expWr;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  logic preloadEn;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int assertCount = 0;
  int failCount   = 0;

  // Environment memory: one-cycle registered read, no reset of its contents.
  logic [31:0] memArray [0:MEM_DEPTH-1];
  always @(posedge clock) begin
    if (preloadEn) begin
      for (int i = 0; i < MEM_DEPTH; i++) memArray[i] <= 32'd0;
      memArray[1] <= 32'd4;
      memArray[2] <= 32'd30;
      memArray[3] <= 32'd19;
      bus.mem_dataout <= 32'd0;
    end else begin
      if (bus.mem_write && bus.mem_address < 32'(MEM_DEPTH))
        memArray[int'(bus.mem_address)] <= bus.mem_datain;
      if (bus.mem_read)
        bus.mem_dataout <= (bus.mem_address < 32'(MEM_DEPTH)) ?
                           memArray[int'(bus.mem_address)] : 32'd0;
    end
  end

  // Bus monitor: strobe counts, last strobe contents and accept times.
  int          readCount  = 0;
  int          writeCount = 0;
  int          bothCount  = 0;
  int          cycleCount = 0;
  logic [31:0] lastStbAddr = '0;
  logic [31:0] lastStbData = '0;
  int          acceptTimes[$];
  always @(posedge clock) begin
    cycleCount <= cycleCount + 1;
    if (bus.mem_read)  readCount  <= readCount + 1;
    if (bus.mem_write) writeCount <= writeCount + 1;
    if (bus.mem_read && bus.mem_write) bothCount <= bothCount + 1;
    if (bus.mem_read || bus.mem_write) begin
      lastStbAddr <= bus.mem_address;
      lastStbData <= bus.mem_datain;
    end
    if (!reset && bus.req_valid && bus.req_ready) acceptTimes.push_back(cycleCount);
  end

  // Reference memory image maintained purely from request semantics.
  logic [31:0] refMem [0:MEM_DEPTH-1];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic modelResp(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic expErr, output logic [31:0] expData,
                           output int expLat, output int expRd, output int expWr);
    if (a >= 32'(MEM_DEPTH)) begin
      expErr = 1'b1; expData = 32'd0; expLat = 1; expRd = 0; expWr = 0;
    end else if (w) begin
      refMem[int'(a)] = d;
      expErr = 1'b0; expData = 32'd0; expLat = 3; expRd = 0; expWr = 1;
    end else begin
      expErr = 1'b0; expData = refMem[int'(a)]; expLat = 3; expRd = 1; expWr = 0;
    end
  endtask

  // One complete transaction with all its checks; called at a negedge.
  task automatic applyStimulus(input string tag, input vec_t v);
    int waitCount;
    int lat;
    int rd0;
    int wr0;
    waitCount = 0;
    while (!bus.req_ready && waitCount < 20) begin
      @(negedge clock);
      waitCount++;
    end
    if (waitCount >= 20) checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
    rd0 = readCount;
    wr0 = writeCount;
    bus.req_valid  = 1'b1;
    bus.req_write  = v.write;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.resp_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    checkOutput({tag, "_ready_low"}, 32'(bus.req_ready), 32'd0);
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clock);
      @(negedge clock);
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(v.expLat));
    checkOutput({tag, "_err"}, 32'(bus.resp_err), 32'(v.expErr));
    checkOutput({tag, "_rdata"}, bus.resp_rdata, v.expRdata);
    for (int i = 0; i < v.delay; i++) begin
      @(posedge clock);
      @(negedge clock);
      checkOutput({tag, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
      checkOutput({tag, "_hold_rdata"}, bus.resp_rdata, v.expRdata);
      checkOutput({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.resp_ready = 1'b0;
    checkOutput({tag, "_valid_clear"}, 32'(bus.resp_valid), 32'd0);
    checkOutput({tag, "_ready_back"}, 32'(bus.req_ready), 32'd1);
    checkOutput({tag, "_rd_pulses"}, 32'(readCount - rd0), 32'(v.expRd));
    checkOutput({tag, "_wr_pulses"}, 32'(writeCount - wr0), 32'(v.expWr));
    if (v.expRd + v.expWr > 0) begin
      checkOutput({tag, "_stb_addr"}, lastStbAddr, v.addr);
      if (v.expWr > 0) checkOutput({tag, "_stb_data"}, lastStbData, v.wdata);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"},  32'(bus.req_ready),  32'd1);
    checkOutput({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    checkOutput({tag, "_resp_rdata"}, bus.resp_rdata,      32'd0);
    checkOutput({tag, "_resp_err"},   32'(bus.resp_err),   32'd0);
    checkOutput({tag, "_mem_read"},   32'(bus.mem_read),   32'd0);
    checkOutput({tag, "_mem_write"},  32'(bus.mem_write),  32'd0);
    checkOutput({tag, "_mem_addr"},   bus.mem_address,     32'd0);
    checkOutput({tag, "_mem_datain"}, bus.mem_datain,      32'd0);
  endtask

  vec_t vecs [9];

  initial begin
    vec_t v;
    int   startIdx;
    int   waitCount;

    for (int i = 0; i < MEM_DEPTH; i++) refMem[i] = 32'd0;
    refMem[1] = 32'd4;
    refMem[2] = 32'd30;
    refMem[3] = 32'd19;

    //            write  addr           wdata         dly err  rdata          lat rd wr
    vecs[0] = '{1'b0, 32'd2,          32'd0,        0, 1'b0, 32'd30,        3, 1, 0};
    vecs[1] = '{1'b1, 32'd5,          32'hDEADBEEF, 0, 1'b0, 32'd0,         3, 0, 1};
    vecs[2] = '{1'b0, 32'd5,          32'd0,        0, 1'b0, 32'hDEADBEEF,  3, 1, 0};
    vecs[3] = '{1'b0, 32'd6536,       32'd0,        0, 1'b1, 32'd0,         1, 0, 0};
    vecs[4] = '{1'b0, 32'hFFFFFFFF,   32'd0,        1, 1'b1, 32'd0,         1, 0, 0};
    vecs[5] = '{1'b0, 32'd3,          32'd0,        5, 1'b0, 32'd19,        3, 1, 0};
    vecs[6] = '{1'b1, 32'd6535,       32'h12345678, 0, 1'b0, 32'd0,         3, 0, 1};
    vecs[7] = '{1'b0, 32'd6535,       32'd0,        2, 1'b0, 32'h12345678,  3, 1, 0};
    vecs[8] = '{1'b1, 32'd6536,       32'h55555555, 0, 1'b1, 32'd0,         1, 0, 0};

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    reset          = 1'b1;
    preloadEn      = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset     = 1'b0;
    preloadEn = 1'b0;
    checkResetValues("por");

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      logic        e;
      logic [31:0] d;
      int          l, r, w;
      modelResp(vecs[i].write, vecs[i].addr, vecs[i].wdata, e, d, l, r, w);
      applyStimulus($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-to-back: request held high, response always taken.
    startIdx       = acceptTimes.size();
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = 32'd2;
    bus.resp_ready = 1'b1;
    repeat (18) @(negedge clock);
    bus.req_valid = 1'b0;
    repeat (6) @(negedge clock);
    bus.resp_ready = 1'b0;
    checkOutput("b2b_accepts", 32'(acceptTimes.size() - startIdx), 32'd5);
    for (int k = 1; k < 5; k++)
      checkOutput($sformatf("b2b_interval%0d", k),
                  32'(acceptTimes[startIdx + k] - acceptTimes[startIdx + k - 1]), 32'd4);

    // Reset while a load of address 3 sits in CAPTURE.
    waitCount = 0;
    while (!bus.req_ready && waitCount < 20) begin
      @(negedge clock);
      waitCount++;
    end
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'd3;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checkResetValues("midrst");
    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
      checkOutput("midrst_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    v = '{1'b0, 32'd1, 32'd0, 0, 1'b0, 32'd4, 3, 1, 0};
    applyStimulus("post_rst_load1", v);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 30; n++) begin
      v.write = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0)
        v.addr = 32'(MEM_DEPTH) + 32'($urandom_range(0, 1000));
      else
        v.addr = 32'($urandom_range(0, 15));
      v.wdata = $urandom;
      v.delay = $urandom_range(0, 3);
      modelResp(v.write, v.addr, v.wdata, v.expErr, v.expRdata, v.expLat, v.expRd, v.expWr);
      applyStimulus($sformatf("rnd%0d", n), v);
    end

    checkOutput("strobes_never_both", 32'(bothCount), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side controller for the single-port, word-addressed data memory. It sits between the CPU MEM stage and the memory. It accepts one load or store request at a time over a valid/ready handshake and drives the memory's read/write/address/datain pins. It absorbs the memory's one-cycle registered read latency and returns each result over a valid/ready response channel, with range checking against the memory depth.

## Interface
- DATA_W, 32, data width of CPU and memory words
- ADDR_W, 32, address width (word index, no byte offset)
- MEM_DEPTH, 6536, number of implemented memory words; addresses >= MEM_DEPTH are errors
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- req_valid  in  1  CPU request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- resp_valid  out  1  response present
- resp_ready  in  1  CPU takes response
- resp_rdata  out  DATA_W  load data (0 for stores and errors)
- resp_err  out  1  address out of range
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_address  out  ADDR_W  memory word address
- mem_datain  out  DATA_W  memory write data
- mem_dataout  in  DATA_W  memory read data, valid the cycle after the edge that sampled mem_read

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, RESP. All outputs are registered.
- IDLE: req_ready=1. On req_valid&&req_ready, latch write/addr/wdata.
  - In range: drive mem_address/mem_datain and raise exactly one of mem_read/mem_write, then go to ACCESS.
  - Out of range (addr >= MEM_DEPTH): no memory strobe; load resp_err=1, resp_rdata=0, resp_valid=1, then go to RESP.
- ACCESS: the memory samples strobes at this edge. Drop mem_read/mem_write (one-cycle pulse) and go to CAPTURE.
- CAPTURE: load resp_rdata=mem_dataout for loads (0 for stores), resp_err=0, resp_valid=1, then go to RESP.
- RESP: hold resp_* stable while resp_ready=0. On resp_ready, clear resp_valid and go to IDLE with req_ready=1.
- mem_address/mem_datain hold their last value outside ACCESS. mem_read and mem_write are never high together.
- Comparison against MEM_DEPTH is unsigned over the full ADDR_W.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_address=0, mem_datain=0.
- Reset has priority over a handshake in the same cycle; the request is dropped.
- Accept edge E. Strobe high during cycle E..E+1. Memory acts at E+1. resp_valid rises after E+2.
- Load/store latency: 3 edges from acceptance to resp_valid. Error latency: 1 edge.
- Minimum occupancy is 4 cycles per transaction (resp_ready held high). req_ready is low from acceptance until the edge after the response handshake.
- Reset mid-operation returns to IDLE and discards the pending response. The memory has no reset, so a write strobed at the same edge as reset still lands.
- resp_ready asserted outside RESP is ignored.

## Structure
- Shared CPU package/header holds the FSM state encodings (2-bit), MEM_DEPTH, and the data/address widths. The data memory uses the same MEM_DEPTH constant.
- Single module, no sub-module; the FSM and datapath registers are small enough to stay flat.

## Test plan
- Memory preloaded word 2 = 30; load addr 2 -> mem_read pulses 1 cycle with mem_address=2; resp_valid 3 edges after accept; resp_rdata=30, resp_err=0.
- Store 0xDEADBEEF to addr 5, then load addr 5 -> single mem_write pulse with mem_datain=0xDEADBEEF; second response rdata=0xDEADBEEF.
- Load addr 6536 and addr 0xFFFFFFFF -> no mem strobe; resp_valid 1 edge after accept; resp_err=1, rdata=0.
- Load addr 3 (=19) with resp_ready low 5 cycles -> resp_valid/rdata=19 held stable; req_ready stays 0; next request accepted only after the handshake.
- Back-to-back requests with req_valid held high and resp_ready=1 -> one accept every 4 cycles; mem_read and mem_write never both 1.
- Reset asserted in CAPTURE of a load -> next edge all outputs at reset values, no resp_valid; a following load of addr 1 returns 4.
